// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet transmit-side buffer unloader.
// The derived constants describe the default 64-bit buffer / 8-bit stream pairing.
package eth_tx_pkg;

    localparam int DEF_MEM_W      = 64;
    localparam int DEF_AXIS_W     = 8;
    localparam int BYTES_PER_WORD = DEF_MEM_W / DEF_AXIS_W;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/tx_frame_reader.sv
// Reads one frame out of the wide packet buffer and serialises it, low byte
// first, onto an AXI-Stream byte interface with full backpressure support.
module tx_frame_reader
    import eth_tx_pkg::*;
#(
    parameter int MEM_W  = DEF_MEM_W,
    parameter int AXIS_W = DEF_AXIS_W,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [MEM_W-1:0]  mem_rdata_i,
    output logic [AXIS_W-1:0] m_axis_tdata_o,
    output logic              m_axis_tvalid_o,
    input  logic              m_axis_tready_i,
    output logic              m_axis_tlast_o
);

    localparam int BPW = MEM_W / AXIS_W;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(BPW - 1);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] mem_addr_q, next_addr_q;
    logic [LEN_W-1:0]  words_left_q, bytes_left_q, len_words;
    logic              mem_en_q, rvalid_q;
    logic [MEM_W-1:0]  cur_q, pf_q;
    logic              cur_valid_q, pf_valid_q;
    logic [IW-1:0]     cur_idx_q;

    logic hs, cur_done, final_hs, start_go, start_zero, issue;

    assign len_words  = (len_i >> IW) + LEN_W'(|len_i[IW-1:0]);
    assign hs         = cur_valid_q & m_axis_tready_i;
    assign final_hs   = hs & (bytes_left_q == ONE);
    assign cur_done   = hs & ((cur_idx_q == LAST_IDX) | (bytes_left_q == ONE));
    assign start_go   = (state_q == IDLE) & start_i & (len_i != '0);
    assign start_zero = (state_q == IDLE) & start_i & (len_i == '0);

    // A single read in flight at a time; a word may only be requested when it
    // is guaranteed a home in cur or pf on arrival.
    assign issue = (state_q == RUN) & (words_left_q != '0) & ~mem_en_q & ~rvalid_q
                 & (~pf_valid_q | cur_done);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d = RUN;
                end else if (start_zero) begin
                    state_d = DONE;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (final_hs) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_en_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            mem_addr_q   <= '0;
            next_addr_q  <= '0;
            words_left_q <= '0;
            bytes_left_q <= '0;
        end else begin
            mem_en_q <= start_go | issue;
            rvalid_q <= mem_en_q;
            if (start_go) begin
                mem_addr_q   <= base_i;
                next_addr_q  <= base_i + ADDR_W'(1);
                words_left_q <= len_words - ONE;
                bytes_left_q <= len_i;
            end else begin
                if (issue) begin
                    mem_addr_q   <= next_addr_q;
                    next_addr_q  <= next_addr_q + ADDR_W'(1);
                    words_left_q <= words_left_q - ONE;
                end
                if (hs) begin
                    bytes_left_q <= bytes_left_q - ONE;
                end
            end
        end
    end

    // When cur finishes, pf refills it first; arriving data then backfills pf
    // so nothing returned by the buffer is ever dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q       <= '0;
            pf_q        <= '0;
            cur_valid_q <= 1'b0;
            pf_valid_q  <= 1'b0;
            cur_idx_q   <= '0;
        end else if (cur_done) begin
            cur_idx_q <= '0;
            if (pf_valid_q) begin
                cur_q <= pf_q;
                if (rvalid_q) begin
                    pf_q <= mem_rdata_i;
                end else begin
                    pf_valid_q <= 1'b0;
                end
            end else if (rvalid_q) begin
                cur_q <= mem_rdata_i;
            end else begin
                cur_valid_q <= 1'b0;
            end
        end else begin
            if (hs) begin
                cur_idx_q <= cur_idx_q + IW'(1);
            end
            if (rvalid_q) begin
                if (!cur_valid_q) begin
                    cur_q       <= mem_rdata_i;
                    cur_valid_q <= 1'b1;
                    cur_idx_q   <= '0;
                end else begin
                    pf_q       <= mem_rdata_i;
                    pf_valid_q <= 1'b1;
                end
            end
        end
    end

    assign mem_en_o        = mem_en_q;
    assign mem_addr_o      = mem_addr_q;
    assign m_axis_tvalid_o = cur_valid_q;
    assign m_axis_tdata_o  = cur_q[cur_idx_q * AXIS_W +: AXIS_W];
    assign m_axis_tlast_o  = cur_valid_q & (bytes_left_q == ONE);

endmodule
